// File: rtl/soc_mem_io.sv
// soc_mem_io: CPU memory-port responder. Word RAM plus a small IO page
// (LEDs, 8N1 UART transmitter, status). Reads have one cycle of registered
// latency; stores honour byte strobes.
// Optional: define SOC_CYCLE_COUNTER_EN to add a free-running cycle counter
// readable at IO offset 3.
module soc_mem_io #(
  parameter int MEM_WORDS = 1024,
  parameter int LED_W     = 5,
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_rstrb,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  logic [31:0]      r_ram [MEM_WORDS];
  logic [31:0]      r_rdata;
  logic [LED_W-1:0] r_leds;

  uart_st_t         r_state, w_state_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [2:0]       r_bit,   w_bit_n;
  logic [BW-1:0]    r_baud,  w_baud_n;
  logic             r_busy,  w_busy_n;
  logic             r_tx,    w_tx_n;

  // Address decode; a strobed write during reset is discarded everywhere.
  logic          w_io;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_sel;
  logic          w_wr, w_ram_we, w_io_we, w_led_we, w_tx_wr, w_baud_end;
  logic [31:0]   w_io_rd, w_rd_word;
  logic          w_unused;

  assign w_io       = mem_addr[22];
  assign w_idx      = mem_addr[AW+1:2];
  assign w_sel      = mem_addr[4:2];
  assign w_wr       = |mem_wstrb;
  assign w_ram_we   = rst & w_wr & ~w_io;
  assign w_io_we    = rst & w_wr & w_io;
  assign w_led_we   = w_io_we && (w_sel == 3'd0);
  assign w_tx_wr    = w_io_we && (w_sel == 3'd1);
  assign w_baud_end = (r_baud == BW'(DIV - 1));
  assign w_unused   = &{1'b0, mem_addr[31:23], mem_addr[21:AW+2], mem_addr[1:0]};

  assign mem_rdata = r_rdata;
  assign leds      = r_leds;
  assign uart_tx   = r_tx;

`ifdef SOC_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) r_cycles <= '0;
    else      r_cycles <= r_cycles + 32'd1;
  end
`endif

  // Word RAM with per-byte write enables; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_ram_we && mem_wstrb[i]) r_ram[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Read source select; all values are pre-edge, giving read-before-write.
  always_comb begin
    w_io_rd = '0;
    case (w_sel)
      3'd0: w_io_rd[LED_W-1:0] = r_leds;
      3'd2: w_io_rd[0]         = r_busy;
`ifdef SOC_CYCLE_COUNTER_EN
      3'd3: w_io_rd            = r_cycles;
`endif
      default: ;
    endcase
    w_rd_word = w_io ? w_io_rd : r_ram[w_idx];
  end

  // Read-data and LED registers; read data only changes on a read strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
      r_leds  <= '0;
    end else begin
      if (mem_rstrb) r_rdata <= w_rd_word;
      if (w_led_we)  r_leds  <= mem_wdata[LED_W-1:0];
    end
  end

  // UART state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
      r_baud  <= w_baud_n;
      r_busy  <= w_busy_n;
      r_tx    <= w_tx_n;
    end
  end

  // UART next state; the line level is derived from the next state so the
  // pin is a clean register output.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_baud_n  = r_baud;
    w_busy_n  = r_busy;
    case (r_state)
      S_IDLE:
        if (w_tx_wr) begin
          w_shift_n = mem_wdata[7:0];
          w_baud_n  = '0;
          w_busy_n  = 1'b1;
          w_state_n = S_START;
        end
      S_START:
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_DATA;
        end else w_baud_n = r_baud + 1'b1;
      S_DATA:
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_n = S_STOP;
          else               w_bit_n   = r_bit + 3'd1;
        end else w_baud_n = r_baud + 1'b1;
      S_STOP:
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end else w_baud_n = r_baud + 1'b1;
      default: w_state_n = S_IDLE;
    endcase
    case (w_state_n)
      S_START: w_tx_n = 1'b0;
      S_DATA:  w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_soc_mem_io.sv
// tb_soc_mem_io: directed plus randomized stimulus against a behavioural
// model (word array, LED value, UART frame timeline by edge count).
module tb_soc_mem_io;

  localparam int MW  = 1024;
  localparam int DIV = 4;
  localparam logic [31:0] IO_LED  = 32'h0040_0000;
  localparam logic [31:0] IO_DATA = 32'h0040_0004;
  localparam logic [31:0] IO_STAT = 32'h0040_0008;
  localparam logic [31:0] IO_CYC  = 32'h0040_000C;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wstrb;
  logic [4:0]  leds;
  logic        uart_tx;

  soc_mem_io #(.MEM_WORDS(MW), .LED_W(5), .CLK_HZ(16), .BAUD(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .leds(leds), .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state
  logic [31:0] ram_m [MW];
  logic [4:0]  leds_m = '0;
  logic [31:0] rd_m = '0;
  bit          fv = 0;
  int          n0 = 0;
  logic [7:0]  fbyte = '0;
  int          cyc = 0;
  int          rcyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  // A frame accepted at edge n0 keeps busy for the 10*DIV cycles after it.
  function automatic bit busy_at(int m);
    return fv && (m >= n0) && ((m - n0) < 10*DIV);
  endfunction

  function automatic logic tx_at(int m);
    int k;
    if (!busy_at(m)) return 1'b1;
    k = (m - n0) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] io_rd(logic [31:0] a, int n);
    logic [31:0] v;
    v = '0;
    case (a[4:2])
      3'd0: v = {27'd0, leds_m};
      3'd2: v = {31'd0, busy_at(n-1)};
`ifdef SOC_CYCLE_COUNTER_EN
      3'd3: v = 32'(n - 1 - rcyc);
`endif
      default: ;
    endcase
    return v;
  endfunction

  // One clock: drive, update model at the edge, check outputs after it.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic rs,
                      input logic [3:0] ws, input logic rn);
    mem_addr = a; mem_wdata = wd; mem_rstrb = rs; mem_wstrb = ws; rst = rn;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      rcyc = cyc; rd_m = '0; leds_m = '0; fv = 0;
    end else begin
      if (rs) rd_m = a[22] ? io_rd(a, cyc) : ram_m[a[11:2]];
      if (ws != 4'd0) begin
        if (a[22]) begin
          if (a[4:2] == 3'd0) leds_m = wd[4:0];
          else if (a[4:2] == 3'd1 && !busy_at(cyc-1)) begin
            fv = 1; n0 = cyc; fbyte = wd[7:0];
          end
        end else begin
          for (int i = 0; i < 4; i++)
            if (ws[i]) ram_m[a[11:2]][8*i +: 8] = wd[8*i +: 8];
        end
      end
    end
    #1;
    chk("rdata", mem_rdata, rd_m);
    chk("leds", {27'd0, leds}, {27'd0, leds_m});
    chk("tx", {31'd0, uart_tx}, {31'd0, tx_at(cyc)});
    mem_rstrb = 1'b0; mem_wstrb = 4'd0; rst = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    step(a, wd, 1'b0, ws, 1'b1);
  endtask
  task automatic rd(input logic [31:0] a);
    step(a, 32'd0, 1'b1, 4'd0, 1'b1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 32'd0, 1'b0, 4'd0, 1'b1);
  endtask

  logic [31:0] v1, v2;
  logic [44:0] txs;
  logic [7:0]  pat;
  int          busy_cnt;
  bit          done;

  initial begin
    rst = 1'b0; mem_addr = '0; mem_wdata = '0; mem_rstrb = 1'b0; mem_wstrb = '0;

    // reset, with a LED write on the reset edge that must be discarded
    step(IO_LED, 32'h1F, 1'b1, 4'hF, 1'b0);
    step(32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_leds", {27'd0, leds}, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);

    // give RAM words 0..15 known contents
    for (int i = 0; i < 16; i++) wr(32'(i*4), $urandom, 4'hF);

    // word store/load and hold
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);
    chk("word", mem_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("word_hold", mem_rdata, 32'hDEADBEEF);
    end

    // byte/half masks and address wrap
    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'hAAAAAAAA, 4'b0100);
    rd(32'h20);
    chk("sb", mem_rdata, 32'h11AA3344);
    wr(32'h20, 32'hBEEFBEEF, 4'b1100);
    rd(32'h20);
    chk("sh", mem_rdata, 32'hBEEF3344);
    rd(32'h20 + 4*MW);
    chk("wrap", mem_rdata, 32'hBEEF3344);

    // same-cycle read and write of one word returns the old contents
    wr(32'h24, 32'hCAFEF00D, 4'hF);
    step(32'h24, 32'h12345678, 1'b1, 4'hF, 1'b1);
    chk("rbw_old", mem_rdata, 32'hCAFEF00D);
    rd(32'h24);
    chk("rbw_new", mem_rdata, 32'h12345678);

    // LEDs, then a reset carrying a RAM write that must be discarded
    wr(IO_LED, 32'h0000001F, 4'hF);
    chk("led_wr", {27'd0, leds}, 32'h1F);
    rd(IO_LED);
    chk("led_rd", mem_rdata, 32'h1F);
    step(32'h30, 32'h0BADBAD0, 1'b0, 4'hF, 1'b0);
    chk("led_rst", {27'd0, leds}, 32'd0);
    chk("rdata_rst", mem_rdata, 32'd0);
    rd(32'h30);

    // UART frame of 0x55 with a dropped write in the 10th cycle; the
    // remaining slots poll status, so 39 of them fall inside the frame
    wr(IO_DATA, 32'h55, 4'h1);
    txs[0] = uart_tx;
    busy_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      if (i == 9) wr(IO_DATA, 32'h0F, 4'h1);
      else begin
        rd(IO_STAT);
        busy_cnt += int'(mem_rdata[0]);
      end
      txs[i+1] = uart_tx;
    end
    chk("busy_len", 32'(busy_cnt), 32'd39);
    pat = 8'h55;
    for (int k = 0; k < 10; k++)
      chk("frame_bit", {28'd0, txs[4*k +: 4]},
          {28'd0, {4{(k == 0) ? 1'b0 : (k == 9) ? 1'b1 : pat[k-1]}}});
    chk("no_2nd_frame", {20'd0, txs[44:40], 7'd0}, {20'd0, 5'b11111, 7'd0});

    // back-to-back frames via status polling, then reset mid-DATA
    wr(IO_DATA, 32'h3C, 4'h1);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      rd(IO_STAT);
      if (mem_rdata[0] == 1'b0) done = 1;
    end
    chk("poll", {31'd0, done}, 32'd1);
    wr(IO_DATA, 32'hA5, 4'h1);
    chk("b2b_start", {31'd0, uart_tx}, 32'd0);
    idle(3*DIV);
    step(32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    chk("abort_tx", {31'd0, uart_tx}, 32'd1);
    rd(IO_STAT);
    chk("abort_busy", mem_rdata, 32'd0);

    // cycle counter: two reads 7 cycles apart
    rd(IO_CYC);
    v1 = mem_rdata;
    idle(6);
    rd(IO_CYC);
    v2 = mem_rdata;
`ifdef SOC_CYCLE_COUNTER_EN
    chk("cyc_diff", v2 - v1, 32'd7);
`else
    chk("cyc_zero", v1 | v2, 32'd0);
`endif

    // randomized mix of RAM and IO traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  ws;
      if ($urandom_range(0, 9) < 7)
        a = ($urandom & 32'hFFBF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      else
        a = $urandom | 32'h0040_0000;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      step(a, $urandom, 1'($urandom), ws, ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/soc_mem_io.md
Name: soc_mem_io

Overview:
- Bus responder for the CPU memory port: on-chip word RAM plus a small memory-mapped IO page (LED register, 8N1 UART transmitter, status).
- Sits between the cpu core and the board pins.
- Serves instruction fetches, loads and byte/half/word stores with one-cycle registered read latency. This matches the CPU's WAIT->FETCH and BYTE->WAIT_LOADING timing.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- LED_W, 5: LED register width.
- CLK_HZ, 12000000: clock frequency.
- BAUD, 115200: UART bit rate. Bit period DIV = CLK_HZ/BAUD, integer division, must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- mem_addr  in  32  byte address from CPU.
- mem_wdata  in  32  store data, already lane-replicated by CPU.
- mem_rstrb  in  1  read request, one cycle.
- mem_wstrb  in  4  byte write enables; nonzero = write, one cycle.
- mem_rdata  out  32  registered read data.
- leds  out  LED_W  LED register.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Reset (rst=0 at posedge): mem_rdata=0, leds=0, uart_tx=1, UART FSM=IDLE, busy=0, bit counter=0, baud counter=0. RAM contents are not reset.
- Decode: mem_addr[22]=1 selects the IO page; otherwise RAM.
- RAM word index = mem_addr[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo MEM_WORDS.
- IO register select = mem_addr[4:2]. mem_addr[1:0] is ignored in both regions.
- Read: when mem_rstrb=1 at posedge, mem_rdata <= selected word; visible the following cycle.
  - mem_rdata holds its value until the next mem_rstrb; no other event changes it.
  - The full word is always returned; byte/half extraction and sign extension are done by the CPU.
- RAM write: for each i with mem_wstrb[i]=1 at posedge, RAM[index][8i+7:8i] <= mem_wdata[8i+7:8i]. Other bytes are unchanged. Single-cycle, no wait states.
- Same-cycle read and write to the same word: the read returns the old contents (read-before-write); the write still occurs.
- IO map (any nonzero mem_wstrb counts as a full write):
  - 0 LEDS: RW; write leds <= mem_wdata[LED_W-1:0]; read {0, leds}.
  - 1 UART_DATA: W; if busy=0, latch mem_wdata[7:0] and start a frame. A write while busy=1 is silently dropped. Reads return 0.
  - 2 UART_STATUS: R; bit0 = busy, other bits 0. Writes are ignored.
  - 3 CYCLES: see Optional Feature.
  - 4-7: reads return 0, writes are ignored.
- UART FSM (states IDLE, START, DATA, STOP; baud counter counts 0..DIV-1):
  - IDLE: uart_tx=1. On an accepted write: shift <= data, baud counter <= 0, busy <= 1, go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA with bit counter=0.
  - DATA: uart_tx=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After 8 bits go to STOP.
  - STOP: uart_tx=1 for DIV cycles, then IDLE with busy <= 0.
  - Frame = 10*DIV cycles. busy rises the cycle after the accepting write edge and falls at the end of STOP.
  - A new frame can be accepted in the first cycle after busy falls; no idle gap is inserted.
  - A status read in the same cycle as an accepting write returns the old busy value (0).
- Reset mid-frame: the frame aborts, uart_tx returns to 1 the next cycle, and busy clears.
- Reset mid-access: any write strobed in the same edge as rst=0 is discarded.

Optional Feature:
- Macro SOC_CYCLE_COUNTER_EN.
- Defined: a 32-bit free-running counter, reset to 0, increments every cycle and wraps 0xFFFFFFFF -> 0. A read of IO offset 3 returns the counter value sampled at the mem_rstrb edge. Writes are ignored.
- Undefined: no counter logic exists, and offset 3 reads return 0.

Test Plan:
- RAM word store/load: wstrb=4'b1111 addr 0x10 wdata 0xDEADBEEF; then rstrb addr 0x10 -> mem_rdata=0xDEADBEEF exactly one cycle after the strobe, held for 5 idle cycles.
- Byte/half masks:
  - Preload 0x11223344 at 0x20.
  - SB: wstrb 4'b0100, wdata 0xAAAAAAAA -> read 0x11AA3344.
  - SH: wstrb 4'b1100, wdata 0xBEEFBEEF -> read 0xBEEF3344.
  - Address 0x20 + 4*MEM_WORDS reads the same word (wrap).
- LEDs: write 0x0000001F to 0x00400000 -> leds=5'h1F next cycle; read returns 0x1F; rst=0 -> leds=0 and mem_rdata=0.
- UART frame (CLK_HZ=16, BAUD=4, so DIV=4):
  - Write 0x55 to 0x00400004 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - busy=1 for 40 cycles.
  - A second write of 0x0F at cycle 10 is dropped: no second frame.
- Status/back-to-back: poll 0x00400008 until bit0=0, write 0xA5 immediately -> new start bit begins the next cycle; an assertion of rst=0 mid-DATA forces uart_tx=1 and busy=0 the following cycle.
- SOC_CYCLE_COUNTER_EN:
  - Defined: two reads of 0x0040000C issued 7 cycles apart differ by exactly 7.
  - Undefined: both read 0.
